// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache CACHE-instruction responder: op codes,
// the responder state encoding and the IDLE dispatch decoder.
package dcache_pkg;

  localparam int TAG_W      = 20;
  localparam int LINE_WORDS = 8;
  localparam int WORD_BITS  = $clog2(LINE_WORDS);

  localparam logic [2:0] CACHEOP_IWBI = 3'b000;
  localparam logic [2:0] CACHEOP_IST  = 3'b010;
  localparam logic [2:0] CACHEOP_HI   = 3'b100;
  localparam logic [2:0] CACHEOP_HWBI = 3'b101;
  localparam logic [1:0] CACHE_SEL_D  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_ADDR,
    WB_DATA,
    INVAL,
    WRITE_TAG,
    DONE
  } state_t;

  // First state after accepting a request; anything not aimed at the dcache
  // or not a supported op completes without touching the arrays.
  function automatic state_t cacheop_entry(input logic [4:0] op);
    state_t nxt;
    nxt = DONE;
    if (op[1:0] == CACHE_SEL_D) begin
      case (op[4:2])
        CACHEOP_IST:                             nxt = WRITE_TAG;
        CACHEOP_IWBI, CACHEOP_HI, CACHEOP_HWBI:  nxt = LOOKUP;
        default:                                 nxt = DONE;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dcache_cacheop_responder_line_wb_seq.sv
// Streams one cache line from the data array onto the writeback burst port,
// then waits for the write response before signalling done.
module dcache_line_wb_seq
  import dcache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rd_en,
  output logic [WORD_BITS-1:0] rd_word,
  input  logic [31:0]          rd_data,
  output logic                 wvalid,
  output logic [31:0]          wdata,
  output logic                 wlast,
  input  logic                 wready,
  input  logic                 wb_done,
  output logic                 done
);

  typedef enum logic [1:0] {SQ_IDLE, SQ_RUN, SQ_RESP} seq_t;

  seq_t                 phase;
  logic [WORD_BITS:0]   rd_ptr;
  logic                 pend;
  logic [WORD_BITS-1:0] pend_w;
  logic                 cur_v;
  logic [WORD_BITS-1:0] cur_w;
  logic [31:0]          cur_d;
  logic                 fire;

  assign fire = cur_v && wready;
  // Next word is fetched while the current beat is on the bus, so returning
  // data always lands in an empty beat register.
  assign rd_en   = (phase == SQ_RUN) && !pend && !rd_ptr[WORD_BITS] && (!cur_v || fire);
  assign rd_word = rd_en ? rd_ptr[WORD_BITS-1:0] : '0;
  assign wvalid  = cur_v && !rst;
  assign wdata   = cur_v ? cur_d : '0;
  assign wlast   = cur_v && (cur_w == WORD_BITS'(LINE_WORDS - 1));
  assign done    = (phase == SQ_RESP) && wb_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= SQ_IDLE;
      rd_ptr <= '0;
      pend   <= 1'b0;
      cur_v  <= 1'b0;
    end else begin
      case (phase)
        SQ_IDLE: if (start) begin
          phase  <= SQ_RUN;
          rd_ptr <= '0;
        end
        SQ_RUN: begin
          pend <= rd_en;
          if (rd_en) rd_ptr <= rd_ptr + 1'b1;
          if (pend) cur_v <= 1'b1;
          else if (fire) cur_v <= 1'b0;
          if (fire && wlast) phase <= SQ_RESP;
        end
        SQ_RESP: if (wb_done) phase <= SQ_IDLE;
        default: phase <= SQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) pend_w <= rd_ptr[WORD_BITS-1:0];
    if (pend) begin
      cur_d <= rd_data;
      cur_w <= pend_w;
    end
  end

endmodule

// File: rtl/dcache_cacheop_responder.sv
// CACHE-instruction responder for the dcache: index/hit invalidate, index
// store tag and dirty-line writeback. Optional counters: DCACHE_CACHEOP_STATS_EN.
module dcache_cacheop_responder
  import dcache_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int SET_BITS    = 7,
  parameter int OFFSET_BITS = 5,
  localparam int WAY_BITS   = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dcache_req,
  input  logic [4:0]            dcache_op,
  input  logic [31:0]           dcache_addr,
  input  logic [TAG_W-1:0]      dcache_tag,
  input  logic                  dcache_valid,
  input  logic                  dcache_dirty,
  output logic                  dcache_ok,
  output logic                  busy,
  output logic                  tag_rd_en,
  output logic [SET_BITS-1:0]   tag_rd_idx,
  input  logic [WAYS*TAG_W-1:0] tag_rd_tag,
  input  logic [WAYS-1:0]       tag_rd_v,
  input  logic [WAYS-1:0]       tag_rd_d,
  output logic                  tag_wr_en,
  output logic [WAY_BITS-1:0]   tag_wr_way,
  output logic [SET_BITS-1:0]   tag_wr_idx,
  output logic [TAG_W-1:0]      tag_wr_tag,
  output logic                  tag_wr_v,
  output logic                  tag_wr_d,
  output logic                  data_rd_en,
  output logic [WAY_BITS-1:0]   data_rd_way,
  output logic [SET_BITS-1:0]   data_rd_idx,
  output logic [2:0]            data_rd_word,
  input  logic [31:0]           data_rd_data,
  output logic                  wb_req,
  output logic [31:0]           wb_addr,
  input  logic                  wb_addr_ok,
  output logic                  wb_wvalid,
  output logic [31:0]           wb_wdata,
  output logic                  wb_wlast,
  input  logic                  wb_wready,
  input  logic                  wb_done
`ifdef DCACHE_CACHEOP_STATS_EN
  ,
  output logic [31:0]           stat_ops,
  output logic [31:0]           stat_wbs
`endif
);

  state_t                state;
  logic                  just_done;
  logic                  accept;
  logic [2:0]            op_q;
  logic [TAG_W-1:0]      atag_q;
  logic [SET_BITS-1:0]   idx_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  v_q;
  logic                  d_q;
  logic [WAY_BITS-1:0]   way_q;
  logic [TAG_W-1:0]      line_tag_q;
  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic                  hit_op;
  logic [WAY_BITS-1:0]   tgt_way;
  logic                  tgt_v;
  logic                  tgt_d;
  logic [TAG_W-1:0]      tgt_tag;
  logic                  seq_start;
  logic                  seq_done;
  logic                  unused_ok;

  assign unused_ok = ^{dcache_addr[OFFSET_BITS-1:0]};

  // The request is still held during the cycle after ok; skip that cycle.
  assign accept    = (state == IDLE) && dcache_req && !just_done;
  assign tag_rd_en = accept && !rst && (cacheop_entry(dcache_op) == LOOKUP);
  assign tag_rd_idx = tag_rd_en ? dcache_addr[OFFSET_BITS +: SET_BITS] : '0;

  // Lowest-numbered valid matching way wins when several ways hit.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tag_rd_v[w] && (tag_rd_tag[w*TAG_W +: TAG_W] == atag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  assign hit_op  = (op_q == CACHEOP_HI) || (op_q == CACHEOP_HWBI);
  assign tgt_way = hit_op ? hit_way : way_q;
  assign tgt_v   = hit_op ? hit : tag_rd_v[way_q];
  assign tgt_d   = tag_rd_d[tgt_way];
  assign tgt_tag = tag_rd_tag[tgt_way*TAG_W +: TAG_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      just_done <= 1'b0;
    end else begin
      just_done <= (state == DONE);
      case (state)
        IDLE:      if (accept) state <= cacheop_entry(dcache_op);
        LOOKUP: begin
          if (!tgt_v)                   state <= DONE;
          else if (op_q == CACHEOP_HI)  state <= INVAL;
          else if (tgt_d)               state <= WB_ADDR;
          else                          state <= INVAL;
        end
        WB_ADDR:   if (wb_addr_ok) state <= WB_DATA;
        WB_DATA:   if (seq_done) state <= INVAL;
        INVAL:     state <= DONE;
        WRITE_TAG: state <= DONE;
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= dcache_op[4:2];
      atag_q <= dcache_addr[31 -: TAG_W];
      idx_q  <= dcache_addr[OFFSET_BITS +: SET_BITS];
      way_q  <= dcache_addr[OFFSET_BITS+SET_BITS +: WAY_BITS];
      tag_q  <= dcache_tag;
      v_q    <= dcache_valid;
      d_q    <= dcache_dirty;
    end else if (state == LOOKUP) begin
      way_q      <= tgt_way;
      line_tag_q <= tgt_tag;
    end
  end

  assign dcache_ok  = (state == DONE);
  assign busy       = (state != IDLE);
  assign tag_wr_en  = (state == INVAL) || (state == WRITE_TAG);
  assign tag_wr_way = tag_wr_en ? way_q : '0;
  assign tag_wr_idx = tag_wr_en ? idx_q : '0;
  assign tag_wr_tag = (state == WRITE_TAG) ? tag_q : ((state == INVAL) ? line_tag_q : '0);
  assign tag_wr_v   = (state == WRITE_TAG) && v_q;
  assign tag_wr_d   = (state == WRITE_TAG) && d_q;

  assign wb_req    = (state == WB_ADDR) && !rst;
  assign wb_addr   = wb_req ? {line_tag_q, idx_q, {OFFSET_BITS{1'b0}}} : '0;
  assign seq_start = (state == WB_ADDR) && wb_addr_ok;

  assign data_rd_way = data_rd_en ? way_q : '0;
  assign data_rd_idx = data_rd_en ? idx_q : '0;

  dcache_line_wb_seq u_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (seq_start),
    .rd_en   (data_rd_en),
    .rd_word (data_rd_word),
    .rd_data (data_rd_data),
    .wvalid  (wb_wvalid),
    .wdata   (wb_wdata),
    .wlast   (wb_wlast),
    .wready  (wb_wready),
    .wb_done (wb_done),
    .done    (seq_done)
  );

`ifdef DCACHE_CACHEOP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops <= '0;
      stat_wbs <= '0;
    end else begin
      if (dcache_ok) stat_ops <= stat_ops + 32'd1;
      if (wb_done)   stat_wbs <= stat_wbs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_cacheop_responder.sv
// Scoreboard bench for dcache_cacheop_responder with behavioural tag/data
// arrays and a writeback slave.
module tb_dcache_cacheop_responder;

  localparam int WAYS = 2;

  logic        clk;
  logic        rst;
  logic        dcache_req;
  logic [4:0]  dcache_op;
  logic [31:0] dcache_addr;
  logic [19:0] dcache_tag;
  logic        dcache_valid;
  logic        dcache_dirty;
  logic        dcache_ok;
  logic        busy;
  logic        tag_rd_en;
  logic [6:0]  tag_rd_idx;
  logic [39:0] tag_rd_tag;
  logic [1:0]  tag_rd_v;
  logic [1:0]  tag_rd_d;
  logic        tag_wr_en;
  logic        tag_wr_way;
  logic [6:0]  tag_wr_idx;
  logic [19:0] tag_wr_tag;
  logic        tag_wr_v;
  logic        tag_wr_d;
  logic        data_rd_en;
  logic        data_rd_way;
  logic [6:0]  data_rd_idx;
  logic [2:0]  data_rd_word;
  logic [31:0] data_rd_data;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic        wb_addr_ok;
  logic        wb_wvalid;
  logic [31:0] wb_wdata;
  logic        wb_wlast;
  logic        wb_wready;
  logic        wb_done;
`ifdef DCACHE_CACHEOP_STATS_EN
  logic [31:0] stat_ops;
  logic [31:0] stat_wbs;
`endif

  dcache_cacheop_responder #(.WAYS(2), .SET_BITS(7), .OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .dcache_req(dcache_req), .dcache_op(dcache_op), .dcache_addr(dcache_addr),
    .dcache_tag(dcache_tag), .dcache_valid(dcache_valid), .dcache_dirty(dcache_dirty),
    .dcache_ok(dcache_ok), .busy(busy),
    .tag_rd_en(tag_rd_en), .tag_rd_idx(tag_rd_idx), .tag_rd_tag(tag_rd_tag),
    .tag_rd_v(tag_rd_v), .tag_rd_d(tag_rd_d),
    .tag_wr_en(tag_wr_en), .tag_wr_way(tag_wr_way), .tag_wr_idx(tag_wr_idx),
    .tag_wr_tag(tag_wr_tag), .tag_wr_v(tag_wr_v), .tag_wr_d(tag_wr_d),
    .data_rd_en(data_rd_en), .data_rd_way(data_rd_way), .data_rd_idx(data_rd_idx),
    .data_rd_word(data_rd_word), .data_rd_data(data_rd_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_addr_ok(wb_addr_ok),
    .wb_wvalid(wb_wvalid), .wb_wdata(wb_wdata), .wb_wlast(wb_wlast),
    .wb_wready(wb_wready), .wb_done(wb_done)
`ifdef DCACHE_CACHEOP_STATS_EN
    , .stat_ops(stat_ops), .stat_wbs(stat_wbs)
`endif
  );

  typedef struct packed {
    logic        way;
    logic [6:0]  idx;
    logic [19:0] tag;
    logic        v;
    logic        d;
    int          min_done;
  } twr_t;

  twr_t        tq[$];
  logic [31:0] aq[$];
  logic [32:0] bq[$];

  int n_chk = 0;
  int n_fail = 0;
  int ok_cnt = 0;
  int wbdone_cnt = 0;
  int wmode = 0;

  logic [19:0] tmem [WAYS][128];
  logic        vmem [WAYS][128];
  logic        dmem [WAYS][128];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dpat(input logic w, input logic [6:0] i, input logic [2:0] k);
    return {4'hD, 11'd0, w, i, 6'd0, k};
  endfunction

  task automatic set_line(input int w, input int i, input logic [19:0] t, input logic v, input logic d);
    tmem[w][i] = t;
    vmem[w][i] = v;
    dmem[w][i] = d;
  endtask

  // Behavioural tag and data arrays, one-cycle read latency.
  always @(posedge clk) begin
    if (tag_rd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_rd_tag[w*20 +: 20] <= tmem[w][tag_rd_idx];
        tag_rd_v[w]            <= vmem[w][tag_rd_idx];
        tag_rd_d[w]            <= dmem[w][tag_rd_idx];
      end
    end
    if (data_rd_en) data_rd_data <= dpat(data_rd_way, data_rd_idx, data_rd_word);
  end

  // Writeback slave: wmode 0 always ready, 1 toggling ready, 2 stalls after 3 beats.
  initial begin
    int fires;
    int done_dly;
    bit tgl;
    fires = 0; done_dly = 0; tgl = 1'b0;
    wb_addr_ok = 1'b0; wb_wready = 1'b0; wb_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      wb_done = 1'b0;
      if (done_dly > 0) begin
        done_dly--;
        if (done_dly == 0) begin
          wb_done = 1'b1;
          wbdone_cnt++;
        end
      end
      wb_addr_ok = wb_req;
      if (wb_req) fires = 0;
      case (wmode)
        1:       begin tgl = ~tgl; wb_wready = tgl; end
        2:       wb_wready = (fires < 3);
        default: wb_wready = 1'b1;
      endcase
      if (wb_wvalid && wb_wready) begin
        fires++;
        if (wb_wlast) done_dly = 3;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (dcache_ok) ok_cnt++;
      if (tag_wr_en) begin
        if (tq.size() == 0) check("tag_wr_unexpected", 1, 0);
        else begin
          twr_t e;
          e = tq.pop_front();
          check("tag_wr_way", tag_wr_way, e.way);
          check("tag_wr_idx", tag_wr_idx, e.idx);
          check("tag_wr_tag", tag_wr_tag, e.tag);
          check("tag_wr_vd", {tag_wr_v, tag_wr_d}, {e.v, e.d});
          check("inval_after_done", wbdone_cnt >= e.min_done, 1);
        end
      end
      if (wb_req && wb_addr_ok) begin
        if (aq.size() == 0) check("wb_req_unexpected", 1, 0);
        else check("wb_addr", wb_addr, aq.pop_front());
      end
      if (wb_wvalid && wb_wready) begin
        if (bq.size() == 0) check("wb_beat_unexpected", 1, 0);
        else check("wb_beat", {wb_wlast, wb_wdata}, bq.pop_front());
      end
    end
  end

  task automatic push_line(input logic w, input logic [6:0] i);
    for (int k = 0; k < 8; k++) bq.push_back({(k == 7), dpat(w, i, 3'(k))});
  endtask

  // Called at posedge+1 with the DUT idle; drives one request to completion.
  task automatic do_op(input logic [4:0] op, input logic [31:0] addr, input logic [19:0] tg,
                       input logic v, input logic d, input int lat, input logic rd);
    int c;
    bit got;
    dcache_op = op; dcache_addr = addr; dcache_tag = tg;
    dcache_valid = v; dcache_dirty = d; dcache_req = 1'b1;
    @(negedge clk);
    check("tag_rd_en", tag_rd_en, rd);
    if (rd) check("tag_rd_idx", tag_rd_idx, addr[11:5]);
    c = 0; got = 1'b0;
    while (!got && c < 400) begin
      @(posedge clk); #1;
      c++;
      @(negedge clk);
      if (dcache_ok) got = 1'b1;
    end
    check("ok_seen", got, 1);
    if (lat >= 0) check("ok_latency", c, lat);
    @(posedge clk); #1;
    @(negedge clk);
    check("ok_single_pulse", dcache_ok, 0);
    check("held_req_ignored", {busy, tag_rd_en}, 2'b00);
    @(posedge clk); #1;
    dcache_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    int ok_before;
    bit seen;
    rst = 1'b1; dcache_req = 1'b0; dcache_op = '0; dcache_addr = '0;
    dcache_tag = '0; dcache_valid = 1'b0; dcache_dirty = 1'b0;
    for (int w = 0; w < WAYS; w++)
      for (int i = 0; i < 128; i++) set_line(w, i, 20'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {dcache_ok, busy, tag_rd_en, tag_wr_en, data_rd_en, wb_req, wb_wvalid, wb_wlast},
          8'h00);
    check("reset_buses", {wb_addr, wb_wdata, tag_wr_tag}, 84'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, dcache_ok}, 2'b00);
    @(posedge clk); #1;

    // Index Store Tag
    tq.push_back('{way: 1'b1, idx: 7'd2, tag: 20'hABCDE, v: 1'b1, d: 1'b1, min_done: 0});
    do_op(5'b01001, 32'h0000_1040, 20'hABCDE, 1'b1, 1'b1, 2, 1'b0);

    // Hit Invalidate on a dirty line: no writeback
    set_line(0, 2, 20'h11111, 1'b1, 1'b0);
    set_line(1, 2, 20'hABCDE, 1'b1, 1'b1);
    tq.push_back('{way: 1'b1, idx: 7'd2, tag: 20'hABCDE, v: 1'b0, d: 1'b0, min_done: 0});
    do_op(5'b10001, 32'hABCD_E040, 20'h0, 1'b0, 1'b0, 3, 1'b1);

    // Hit Writeback Invalidate on a dirty line, toggling wready
    set_line(0, 2, 20'hABCDE, 1'b1, 1'b1);
    set_line(1, 2, 20'h22222, 1'b1, 1'b1);
    wmode = 1;
    aq.push_back(32'hABCD_E040);
    push_line(1'b0, 7'd2);
    tq.push_back('{way: 1'b0, idx: 7'd2, tag: 20'hABCDE, v: 1'b0, d: 1'b0, min_done: wbdone_cnt + 1});
    do_op(5'b10101, 32'hABCD_E040, 20'h0, 1'b0, 1'b0, -1, 1'b1);
    wmode = 0;

    // Index Writeback Invalidate on a clean line
    set_line(1, 1, 20'h33333, 1'b1, 1'b0);
    tq.push_back('{way: 1'b1, idx: 7'd1, tag: 20'h33333, v: 1'b0, d: 1'b0, min_done: 0});
    do_op(5'b00001, 32'h0000_1020, 20'h0, 1'b0, 1'b0, 3, 1'b1);

    // Hit Invalidate miss: a matching tag that is not valid must not hit
    set_line(1, 2, 20'h55555, 1'b0, 1'b1);
    do_op(5'b10001, 32'h5555_5040, 20'h0, 1'b0, 1'b0, 2, 1'b1);

    // Undefined op and wrong cache selector
    do_op(5'b11101, 32'hABCD_E040, 20'h0, 1'b0, 1'b0, 1, 1'b0);
    do_op(5'b01000, 32'h0000_1040, 20'hFFFFF, 1'b1, 1'b1, 1, 1'b0);

    // Multiple hits pick way 0
    set_line(0, 3, 20'h44444, 1'b1, 1'b0);
    set_line(1, 3, 20'h44444, 1'b1, 1'b1);
    tq.push_back('{way: 1'b0, idx: 7'd3, tag: 20'h44444, v: 1'b0, d: 1'b0, min_done: 0});
    do_op(5'b10001, 32'h4444_4060, 20'h0, 1'b0, 1'b0, 3, 1'b1);

    // Index Writeback Invalidate on a dirty line: address uses the stored tag
    aq.push_back(32'h4444_4060);
    push_line(1'b1, 7'd3);
    tq.push_back('{way: 1'b1, idx: 7'd3, tag: 20'h44444, v: 1'b0, d: 1'b0, min_done: wbdone_cnt + 1});
    do_op(5'b00001, 32'h0000_1060, 20'h0, 1'b0, 1'b0, -1, 1'b1);

    // Reset while beat 3 is on the bus
    set_line(0, 5, 20'h66666, 1'b1, 1'b1);
    wmode = 2;
    aq.push_back(32'h6666_60A0);
    for (int k = 0; k < 3; k++) bq.push_back({1'b0, dpat(1'b0, 7'd5, 3'(k))});
    dcache_op = 5'b10101; dcache_addr = 32'h6666_60A0; dcache_req = 1'b1;
    c = 0; seen = 1'b0;
    while (!seen && c < 200) begin
      @(posedge clk); #1;
      c++;
      @(negedge clk);
      if (wb_wvalid && !wb_wready) seen = 1'b1;
    end
    check("beat3_presented", seen, 1);
    check("beat3_data", wb_wdata, dpat(1'b0, 7'd5, 3'd3));
    ok_before = ok_cnt;
    @(posedge clk); #1;
    rst = 1'b1; dcache_req = 1'b0;
    @(negedge clk);
    check("rst_drops_wb", {wb_wvalid, wb_req}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    wmode = 0;
    @(negedge clk);
    check("idle_after_rst", {busy, dcache_ok, wb_wvalid}, 3'b000);
    repeat (5) @(posedge clk);
    #1;
    check("no_ok_after_rst", ok_cnt, ok_before);

    // Next Index Store Tag completes normally
    tq.push_back('{way: 1'b1, idx: 7'd2, tag: 20'h12345, v: 1'b1, d: 1'b0, min_done: 0});
    do_op(5'b01001, 32'h0000_1040, 20'h12345, 1'b1, 1'b0, 2, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("tag_queue_drained", tq.size(), 0);
    check("addr_queue_drained", aq.size(), 0);
    check("beat_queue_drained", bq.size(), 0);
    check("ok_total", ok_cnt, 10);
`ifdef DCACHE_CACHEOP_STATS_EN
    check("stat_ops", stat_ops, 32'(ok_cnt));
    check("stat_wbs", stat_wbs, 32'(wbdone_cnt));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
